// File: rtl/rv32_pkg.sv
// RV32I decode constants shared by the ID/EX stage and its immediate generator:
// major opcodes, ALU micro-op codes (funct3 encoding) and instruction field widths.
package rv32_pkg;

  localparam int XLEN_W   = 32;
  localparam int OPC_W    = 7;
  localparam int FUNCT3_W = 3;
  localparam int REG_W    = 5;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  // ALU micro-ops are encoded exactly as RV32I funct3 so OP/OP-IMM pass funct3 straight through.
  typedef enum logic [FUNCT3_W-1:0] {
    UOP_ADD_SUB = 3'b000,
    UOP_SL      = 3'b001,
    UOP_SLT     = 3'b010,
    UOP_SLTU    = 3'b011,
    UOP_XOR     = 3'b100,
    UOP_SR      = 3'b101,
    UOP_OR      = 3'b110,
    UOP_AND     = 3'b111
  } alu_uop_e;

  // Everything the decoder produces for one instruction, before it is registered.
  typedef struct packed {
    logic [XLEN_W-1:0] op1;
    logic [XLEN_W-1:0] op2;
    alu_uop_e          uop;
    logic              f7;
    logic [REG_W-1:0]  rd;
    logic              rd_we;
    logic              illegal;
  } dec_t;

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational immediate extraction for the ALU-class instructions handled by id_ex_stage.
// OP-IMM shifts get a zero-extended shamt, other OP-IMM a sign-extended I-immediate,
// LUI/AUIPC the U-immediate; any other opcode yields zero.
module rv32_imm_gen
  import rv32_pkg::*;
(
  input  logic [XLEN_W-1:0] instr,
  output logic [XLEN_W-1:0] imm
);

  logic [OPC_W-1:0]    opcode;
  logic [FUNCT3_W-1:0] funct3;
  logic                unused_rd;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  // The rd field takes no part in any immediate.
  assign unused_rd = ^instr[11:7];

  // Select the immediate format implied by the opcode.
  always_comb begin
    // NOTE: assign a default before the case so every path drives imm and no latch is inferred.
    imm = '0;
    case (opcode)
      OPC_OP_IMM: begin
        if (funct3 == UOP_SL || funct3 == UOP_SR) begin
          // Shift amount only; instr[30] selects arithmetic shift and is carried as f7 instead.
          imm = {27'b0, instr[24:20]};
        end else begin
          imm = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_LUI, OPC_AUIPC: imm = {instr[31:12], 12'b0};
      default:            imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode + operand-select stage feeding alu_32. Reads the register file combinationally,
// builds op1/op2/uop/f7 and holds them in a single-entry valid/ready pipeline register.
// Optional feature: define ID_EX_FWD_EN to bypass the EX-stage result (fwd_*) into op1/op2.
// Without it the fwd_* ports exist but are ignored and upstream must stall on hazards.
module id_ex_stage
  import rv32_pkg::*;
#(
  parameter int              XLEN   = 32,
  parameter logic [XLEN-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [2:0]      out_uop,
  output logic            out_f7,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal,
  input  logic [4:0]      fwd_rd,
  input  logic            fwd_we,
  input  logic [XLEN-1:0] fwd_data
);

  logic [OPC_W-1:0]    opcode;
  logic [FUNCT3_W-1:0] funct3;
  logic [XLEN-1:0]     imm;
  logic [XLEN-1:0]     rs1_val;
  logic [XLEN-1:0]     rs2_val;
  logic                load;
  dec_t                dec;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  rv32_imm_gen u_imm_gen (
    .instr (in_instr),
    .imm   (imm)
  );

`ifdef ID_EX_FWD_EN
  // Bypass each operand independently from the instruction in EX; x0 is never forwarded.
  assign rs1_val = (fwd_we && fwd_rd != '0 && fwd_rd == rs1_addr) ? fwd_data : rs1_data;
  assign rs2_val = (fwd_we && fwd_rd != '0 && fwd_rd == rs2_addr) ? fwd_data : rs2_data;
`else
  logic unused_fwd;

  assign rs1_val    = rs1_data;
  assign rs2_val    = rs2_data;
  assign unused_fwd = ^{fwd_rd, fwd_we, fwd_data};
`endif

  // Single-entry register: accept when empty or when the held entry leaves this cycle.
  assign in_ready = ~out_valid | out_ready;
  assign load     = in_valid & in_ready & ~flush;

  // Decode the incoming instruction into ALU operands and control.
  always_comb begin
    dec    = '0;
    dec.rd = in_instr[11:7];
    case (opcode)
      OPC_OP: begin
        dec.op1 = rs1_val;
        dec.op2 = rs2_val;
        dec.uop = alu_uop_e'(funct3);
        dec.f7  = in_instr[30];
      end
      OPC_OP_IMM: begin
        dec.op1 = rs1_val;
        dec.op2 = imm;
        dec.uop = alu_uop_e'(funct3);
        // instr[30] is an immediate bit for everything except SRLI/SRAI.
        dec.f7  = (funct3 == UOP_SR) ? in_instr[30] : 1'b0;
      end
      OPC_LUI: begin
        dec.op2 = imm;
      end
      OPC_AUIPC: begin
        dec.op1 = in_pc;
        dec.op2 = imm;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    dec.rd_we = ~dec.illegal & (dec.rd != '0);
  end

  // Pipeline register: flush kills, load captures, a consumed entry drains; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_uop     <= '0;
      out_f7      <= 1'b0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_pc      <= RST_PC;
      out_illegal <= 1'b0;
    end else if (flush) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_op1     <= dec.op1;
      out_op2     <= dec.op2;
      out_uop     <= dec.uop;
      out_f7      <= dec.f7;
      out_rd      <= dec.rd;
      out_rd_we   <= dec.rd_we;
      out_pc      <= in_pc;
      out_illegal <= dec.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a reference decoder pushes expected operand bundles into
// a scoreboard at each accepted handshake and pops them when the stage hands data downstream.
module tb_id_ex_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [2:0]  out_uop;
  logic        out_f7;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_pc;
  logic        out_illegal;
  logic [4:0]  fwd_rd;
  logic        fwd_we;
  logic [31:0] fwd_data;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  uop;
    logic        f7;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] pc;
    logic        illegal;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   last_acc;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RST_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op1     (out_op1),
    .out_op2     (out_op2),
    .out_uop     (out_uop),
    .out_f7      (out_f7),
    .out_rd      (out_rd),
    .out_rd_we   (out_rd_we),
    .out_pc      (out_pc),
    .out_illegal (out_illegal),
    .fwd_rd      (fwd_rd),
    .fwd_we      (fwd_we),
    .fwd_data    (fwd_data)
  );

  // Reference decoder written straight from the RV32I encodings.
  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t       e;
    logic [2:0] f3;
    f3 = instr[14:12];
    e = '0;
    e.rd = instr[11:7];
    e.pc = pc;
`ifdef ID_EX_FWD_EN
    if (fwd_we && fwd_rd != 5'd0 && fwd_rd == instr[19:15]) a = fwd_data;
    if (fwd_we && fwd_rd != 5'd0 && fwd_rd == instr[24:20]) b = fwd_data;
`endif
    case (instr[6:0])
      7'h33: begin e.op1 = a; e.op2 = b; e.uop = f3; e.f7 = instr[30]; end
      7'h13: begin
        e.op1 = a;
        e.uop = f3;
        if (f3 == 3'd1 || f3 == 3'd5) e.op2 = {27'd0, instr[24:20]};
        else                          e.op2 = {{20{instr[31]}}, instr[31:20]};
        e.f7 = (f3 == 3'd5) ? instr[30] : 1'b0;
      end
      7'h37: begin e.op1 = 32'd0; e.op2 = {instr[31:12], 12'd0}; end
      7'h17: begin e.op1 = pc;    e.op2 = {instr[31:12], 12'd0}; end
      default: e.illegal = 1'b1;
    endcase
    e.rd_we = !e.illegal && (e.rd != 5'd0);
    return e;
  endfunction

  // One clock: score the downstream transfer, record an upstream acceptance, advance to next negedge.
  task automatic cycle(input string tag);
    exp_t act, e;
    #1;
    last_acc = 1'b0;
    if (out_valid && out_ready && !flush) begin
      act = {out_op1, out_op2, out_uop, out_f7, out_rd, out_rd_we, out_pc, out_illegal};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL %s unexpected_output got=%h want=<none>", tag, act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL %s out_bundle got=%h want=%h", tag, act, e);
        end
      end
    end
    if (flush) sb.delete();
    if (in_valid && in_ready && !flush) begin
      sb.push_back(model(in_instr, in_pc, rs1_data, rs2_data));
      last_acc = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    rs1_data = a;
    rs2_data = b;
    for (int i = 0; i < 20; i++) begin
      cycle("send");
      if (last_acc) break;
    end
    if (!last_acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout instr=%h got=not_accepted want=accepted", instr);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      cycle("drain");
    end
    total++;
    if (sb.size() != 0 || out_valid) begin
      bad++;
      $display("FAIL drain_timeout got=pending%0d want=pending0", sb.size());
    end
  endtask

  task automatic test_reset();
    logic [107:0] act;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    act = {out_valid, out_op1, out_op2, out_uop, out_f7, out_rd, out_rd_we, out_pc, out_illegal};
    total++;
    if (act !== {1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 5'd0, 1'b0, RST_PC, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", act,
               {1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 5'd0, 1'b0, RST_PC, 1'b0});
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    send(32'h002081B3, 32'h0000_0200, 32'd5, 32'd7);
    total++;
    if ({out_valid, out_op1, out_op2, out_uop, out_f7, out_rd, out_rd_we} !==
        {1'b1, 32'd5, 32'd7, 3'd0, 1'b0, 5'd3, 1'b1}) begin
      bad++;
      $display("FAIL add_direct got=%b/%h/%h/%h/%b/%0d/%b want=1/5/7/0/0/3/1",
               out_valid, out_op1, out_op2, out_uop, out_f7, out_rd, out_rd_we);
    end
    drain();
  endtask

  task automatic test_imm();
    out_ready = 1'b1;
    send(32'h40435293, 32'h0000_0300, 32'h8000_0000, 32'h0000_0123);  // SRAI x5,x6,4
    total++;
    if ({out_op2, out_uop, out_f7} !== {32'd4, 3'b101, 1'b1}) begin
      bad++;
      $display("FAIL srai_direct got=%h/%h/%b want=4/5/1", out_op2, out_uop, out_f7);
    end
    send(32'hFFF00093, 32'h0000_0304, 32'd0, 32'h5555_5555);          // ADDI x1,x0,-1
    total++;
    if ({out_op2, out_f7, out_rd_we} !== {32'hFFFF_FFFF, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL addi_neg_direct got=%h/%b/%b want=ffffffff/0/1", out_op2, out_f7, out_rd_we);
    end
    send(32'h7FF47393, 32'h0000_0308, 32'hDEAD_BEEF, 32'd0);          // ANDI x7,x8,0x7FF (instr[30]=1)
    send(32'h01F51493, 32'h0000_030C, 32'h0000_0001, 32'd0);          // SLLI x9,x10,31
    send(32'h40628233, 32'h0000_0310, 32'd100, 32'd30);               // SUB x4,x5,x6
    send(32'h00208033, 32'h0000_0314, 32'd1, 32'd2);                  // ADD x0,x1,x2 -> rd_we=0
    send(32'hABCDE537, 32'h0000_0318, 32'h1111_1111, 32'h2222_2222);  // LUI x10,0xABCDE
    send(32'h12345117, 32'h0000_0100, 32'h3333_3333, 32'd0);          // AUIPC x2,0x12345
    total++;
    if ({out_op1, out_op2} !== {32'h0000_0100, 32'h1234_5000}) begin
      bad++;
      $display("FAIL auipc_direct got=%h/%h want=00000100/12345000", out_op1, out_op2);
    end
    send(32'h0000007F, 32'h0000_0104, 32'h4444_4444, 32'h5555_5555);  // unsupported opcode
    total++;
    if ({out_valid, out_illegal, out_rd_we, out_op1, out_op2} !== {1'b1, 1'b1, 1'b0, 64'd0}) begin
      bad++;
      $display("FAIL illegal_direct got=%b/%b/%b/%h/%h want=1/1/0/0/0",
               out_valid, out_illegal, out_rd_we, out_op1, out_op2);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [6:0]  opcs [5];
    logic [31:0] r;
    opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h37; opcs[3] = 7'h17; opcs[4] = 7'h03;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      r = $urandom;
      send({r[31:7], opcs[$urandom_range(4, 0)]}, $urandom, $urandom, $urandom);
    end
    drain();
  endtask

  task automatic test_stall();
    exp_t held, act;
    out_ready = 1'b0;
    send(32'h40628233, 32'h0000_0400, 32'd9, 32'd4);  // SUB held in the register
    held = sb[0];
    in_valid = 1'b1;
    in_instr = 32'hABCDE537;
    in_pc    = 32'h0000_0404;
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      act = {out_op1, out_op2, out_uop, out_f7, out_rd, out_rd_we, out_pc, out_illegal};
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || act !== held) begin
        bad++;
        $display("FAIL stall_hold cyc%0d got=%b/%b/%h want=0/1/%h", i, in_ready, out_valid, act, held);
      end
      cycle("stall");
    end
    out_ready = 1'b1;
    cycle("release");
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_op2 !== 32'hABCD_E000 || out_pc !== 32'h0000_0404) begin
      bad++;
      $display("FAIL stall_release got=%b/%h/%h want=1/abcde000/00000404", out_valid, out_op2, out_pc);
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0000_0500, 32'd1, 32'd2);
    in_valid = 1'b1;
    in_instr = 32'h12345117;
    in_pc    = 32'h0000_0504;
    flush    = 1'b1;
    cycle("flush");
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_kill got=%b/%b want=0/1", out_valid, in_ready);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0000_0600, 32'd3, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    total++;
    if (out_valid !== 1'b0 || out_pc !== RST_PC || out_op1 !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid got=%b/%h/%h want=0/%h/0", out_valid, out_pc, out_op1, RST_PC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drain();
  endtask

  task automatic test_forward();
    logic [31:0] want;
    out_ready = 1'b1;
    fwd_we    = 1'b1;
    fwd_rd    = 5'd1;
    fwd_data  = 32'h0000_00AA;
    send(32'h001081B3, 32'h0000_0700, 32'h11, 32'h11);  // ADD x3,x1,x1
`ifdef ID_EX_FWD_EN
    want = 32'h0000_00AA;
`else
    want = 32'h0000_0011;
`endif
    total++;
    if (out_op1 !== want || out_op2 !== want) begin
      bad++;
      $display("FAIL fwd_both got=%h/%h want=%h/%h", out_op1, out_op2, want, want);
    end
    fwd_rd = 5'd0;
    send(32'h000001B3, 32'h0000_0704, 32'h22, 32'h33);  // ADD x3,x0,x0 with fwd_rd=0
    fwd_rd = 5'd2;
    send(32'h002081B3, 32'h0000_0708, 32'h44, 32'h55);  // only op2 matches
    fwd_we = 1'b0;
    send(32'h002081B3, 32'h0000_070C, 32'h66, 32'h77);  // forwarding disabled by fwd_we
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_pc     = 32'd0;
    rs1_data  = 32'd0;
    rs2_data  = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    fwd_rd    = 5'd0;
    fwd_we    = 1'b0;
    fwd_data  = 32'd0;
    test_reset();
    test_add();
    test_imm();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_forward();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
